// File: rtl/enemy_swarm_ctrl.sv
// enemy_swarm_ctrl: formation mover (sweep/advance FSM) with arbitrated hit testing and kill scoring.
// The formation is stored as one origin; every enemy position is derived from it.
module enemy_swarm_ctrl #(
  parameter int NB_ROWS     = 5,
  parameter int NB_COLS     = 10,
  parameter int NB_SHOTS    = 2,
  parameter int CELL_W      = 60,
  parameter int CELL_H      = 60,
  parameter int X0          = 75,
  parameter int Y0          = 65,
  parameter int X_MIN       = 10,
  parameter int X_MAX       = 610,
  parameter int Y_MAX       = 460,
  parameter int STEP_X      = 13,
  parameter int STEP_Y      = 20,
  parameter int BASE_PERIOD = 30,
  parameter int SPEEDUP     = 1,
  parameter int MIN_PERIOD  = 2,
  parameter int MODE        = 0
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          enable,
  input  logic                          freeze,
  input  logic                          frame_tick,
  input  logic [NB_SHOTS-1:0]           hit_valid,
  input  logic [12*NB_SHOTS-1:0]        hit_x,
  input  logic [12*NB_SHOTS-1:0]        hit_y,
  output logic [NB_SHOTS-1:0]           hit_ready,
  output logic [NB_SHOTS-1:0]           hit_kill,
  output logic [12*NB_ROWS*NB_COLS-1:0] enemy_x,
  output logic [12*NB_ROWS*NB_COLS-1:0] enemy_y,
  output logic [NB_ROWS*NB_COLS-1:0]    alive,
  output logic                          kill_valid,
  output logic [11:0]                   kill_x,
  output logic [11:0]                   kill_y,
  output logic [1:0]                    kill_points,
  output logic [1:0]                    status
);
  localparam int N  = NB_ROWS * NB_COLS;
  localparam int KW = $clog2(N + 1);
  typedef enum logic [2:0] {IDLE, MOVE, ADVANCE, WON, LOST} state_t;
  state_t            state_q, state_d;
  logic [11:0]       ox_q, ox_d, oy_q, oy_d;
  logic [N-1:0]      alive_q, alive_d, kmask;
  logic              dir_q, dir_d;
  logic [KW-1:0]     kills_q, kills_d;
  logic [15:0]       cnt_q, cnt_d;
  logic              kv_q, kv_d;
  logic [11:0]       kx_q, kx_d, ky_q, ky_d, hit_kx, hit_ky;
  logic [1:0]        kp_q, kp_d, hit_kp;
  logic [11:0]       ex [N];
  logic [11:0]       ey [N];
  logic [NB_COLS-1:0] colm;
  logic [NB_ROWS-1:0] rowm;
  logic [NB_SHOTS-1:0] grant;
  logic              run, step, blocked, lose, hit_any;
  int                cmin, cmax, rmin, rmax, e_l, e_r, e_t, e_b, hx, hy, red, period;

  for (genvar r = 0; r < NB_ROWS; r++) begin : g_row
    for (genvar c = 0; c < NB_COLS; c++) begin : g_col
      assign ex[r*NB_COLS+c] = ox_q + 12'(c*CELL_W);
      assign ey[r*NB_COLS+c] = oy_q + 12'(r*CELL_H);
      assign enemy_x[12*(r*NB_COLS+c) +: 12] = ex[r*NB_COLS+c];
      assign enemy_y[12*(r*NB_COLS+c) +: 12] = ey[r*NB_COLS+c];
    end
  end

  // bounding box of the living enemies only
  always_comb begin
    colm = '0;
    rowm = '0;
    for (int r = 0; r < NB_ROWS; r++)
      for (int c = 0; c < NB_COLS; c++) begin
        colm[c] = colm[c] | alive_q[r*NB_COLS+c];
        rowm[r] = rowm[r] | alive_q[r*NB_COLS+c];
      end
    cmin = 0;
    cmax = 0;
    rmin = 0;
    rmax = 0;
    for (int c = NB_COLS-1; c >= 0; c--) if (colm[c]) cmin = c;
    for (int c = 0; c < NB_COLS; c++) if (colm[c]) cmax = c;
    for (int r = NB_ROWS-1; r >= 0; r--) if (rowm[r]) rmin = r;
    for (int r = 0; r < NB_ROWS; r++) if (rowm[r]) rmax = r;
    e_l = int'(ox_q) + cmin*CELL_W;
    e_r = int'(ox_q) + (cmax+1)*CELL_W;
    e_t = int'(oy_q) + rmin*CELL_H;
    e_b = int'(oy_q) + (rmax+1)*CELL_H;
    blocked = (MODE == 0) ? (dir_q ? e_l - STEP_X < X_MIN : e_r + STEP_X > X_MAX)
                          : (dir_q ? e_t - STEP_Y < Y0 : e_b + STEP_Y > Y_MAX);
    lose = (MODE == 0) ? e_b + STEP_Y >= Y_MAX : e_r + STEP_X >= X_MAX;
  end

  // lowest channel wins; descending scan leaves the lowest matching enemy
  always_comb begin
    run = enable && (state_q == MOVE || state_q == ADVANCE);
    grant = run ? hit_valid & (-hit_valid) : '0;
    hx = 0;
    hy = 0;
    for (int i = 0; i < NB_SHOTS; i++)
      if (grant[i]) begin
        hx = int'(hit_x[12*i +: 12]);
        hy = int'(hit_y[12*i +: 12]);
      end
    hit_any = 1'b0;
    kmask = '0;
    hit_kx = 12'd0;
    hit_ky = 12'd0;
    hit_kp = 2'd0;
    for (int i = N-1; i >= 0; i--)
      if (|grant && alive_q[i] && hx >= int'(ex[i]) && hx < int'(ex[i]) + CELL_W &&
          hy >= int'(ey[i]) && hy < int'(ey[i]) + CELL_H) begin
        hit_any = 1'b1;
        kmask = '0;
        kmask[i] = 1'b1;
        hit_kx = ex[i];
        hit_ky = ey[i];
        hit_kp = (i < NB_COLS) ? 2'd3 : (i < 3*NB_COLS) ? 2'd2 : 2'd1;
      end
    hit_ready = grant;
    hit_kill = hit_any ? grant : '0;
  end

  always_comb begin
    red = int'(kills_q) * SPEEDUP;
    period = (BASE_PERIOD - red > MIN_PERIOD) ? BASE_PERIOD - red : MIN_PERIOD;
    step = run && !freeze && frame_tick && int'(cnt_q) + 1 >= period;
    state_d = state_q;
    ox_d = ox_q;
    oy_d = oy_q;
    alive_d = alive_q & ~kmask;
    dir_d = dir_q;
    kills_d = (hit_any && kills_q != KW'(N)) ? kills_q + KW'(1) : kills_q;
    cnt_d = (run && !freeze && frame_tick) ? (step ? '0 : cnt_q + 16'd1) : cnt_q;
    kv_d = hit_any;
    kx_d = hit_any ? hit_kx : kx_q;
    ky_d = hit_any ? hit_ky : ky_q;
    kp_d = hit_any ? hit_kp : kp_q;
    if (step && state_q == MOVE) begin
      if (blocked) state_d = ADVANCE;
      else if (MODE == 0) ox_d = dir_q ? ox_q - 12'(STEP_X) : ox_q + 12'(STEP_X);
      else oy_d = dir_q ? oy_q - 12'(STEP_Y) : oy_q + 12'(STEP_Y);
    end
    if (step && state_q == ADVANCE) begin
      if (MODE == 0) oy_d = oy_q + 12'(STEP_Y);
      else ox_d = ox_q + 12'(STEP_X);
      dir_d = ~dir_q;
      state_d = lose ? LOST : MOVE;
    end
    if (run && alive_d == '0) state_d = WON;
    if (state_q == IDLE) state_d = MOVE;
    if (!enable) begin
      state_d = IDLE;
      ox_d = 12'(X0);
      oy_d = 12'(Y0);
      alive_d = '1;
      dir_d = 1'b0;
      kills_d = '0;
      cnt_d = '0;
      kv_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= IDLE;
      ox_q <= 12'(X0);
      oy_q <= 12'(Y0);
      alive_q <= '1;
      dir_q <= 1'b0;
      kills_q <= '0;
      cnt_q <= '0;
      kv_q <= 1'b0;
      kx_q <= '0;
      ky_q <= '0;
      kp_q <= '0;
    end else begin
      state_q <= state_d;
      ox_q <= ox_d;
      oy_q <= oy_d;
      alive_q <= alive_d;
      dir_q <= dir_d;
      kills_q <= kills_d;
      cnt_q <= cnt_d;
      kv_q <= kv_d;
      kx_q <= kx_d;
      ky_q <= ky_d;
      kp_q <= kp_d;
    end

  assign alive = alive_q;
  assign kill_valid = kv_q;
  assign kill_x = kx_q;
  assign kill_y = ky_q;
  assign kill_points = kp_q;
  assign status = (state_q == WON) ? 2'b10 : (state_q == LOST) ? 2'b01 : 2'b00;
endmodule
